// File: rtl/golden_nonce_arbiter.sv
// golden_nonce_arbiter
//   Gathers golden nonces from NUM_CORES hash cores. Each result goes into a
//   per-core holding register. A round-robin arbiter then moves results into
//   a small FIFO, which presents them one 32-bit word at a time to the UART
//   TX framer. A new_work pulse flushes everything, so stale nonces are
//   never reported.
//
//   Optional build macro: GNA_DEDUP_EN. When defined, a granted word equal
//   to the last pushed word is consumed but not pushed.
//
// Parameters
//   NUM_CORES   number of hash cores (1..16)
//   FIFO_DEPTH  result FIFO entries (power of two, >= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   core_valid  per-core one-cycle "nonce found" pulse
//   core_nonce  packed nonces, core i on [32i+31:32i]
//   new_work    flush all pending results
//   tx_ready    TX framer accepts a word
//   tx_valid    tx_data holds a result
//   tx_data     FIFO head word
//   overflow    sticky: a nonce was dropped since last flush/reset
//   pending     any holding register occupied
module golden_nonce_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    core_valid,
  input  logic [32*NUM_CORES-1:0] core_nonce,
  input  logic                    new_work,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [31:0]             tx_data,
  output logic                    overflow,
  output logic                    pending
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0]          hold [NUM_CORES];
  logic [NUM_CORES-1:0] full;
  logic [NUM_CORES-1:0] full_nxt;
  logic [NUM_CORES-1:0] drop;
  logic [NUM_CORES-1:0] capture;
  logic [IW-1:0]        rr;

  logic [31:0]          mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr;
  logic [PW:0]          rd_ptr;
  logic [PW:0]          count;

  logic                 found;
  logic                 grant_vld;
  logic [IW-1:0]        grant_idx;
  logic [31:0]          grant_word;
  logic                 can_accept;
  logic                 pop;
  logic                 push;
  logic                 is_dup;

  // (base + off) mod NUM_CORES, with off < NUM_CORES
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NUM_CORES)) s = s - 32'(NUM_CORES);
    return IW'(s);
  endfunction

  assign count      = wr_ptr - rd_ptr;
  assign tx_valid   = (count != '0);
  assign pop        = tx_valid && tx_ready;
  // A full FIFO can still take a word in a cycle where the head is popped.
  assign can_accept = (count < (PW+1)'(FIFO_DEPTH)) || pop;
  assign pending    = |full;
  assign tx_data    = tx_valid ? mem[rd_ptr[PW-1:0]] : 32'h0;

  // Round-robin scan starting at rr
  always_comb begin
    logic [IW-1:0] idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = wrap_idx(rr, k);
      if (!found && full[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant_vld  = found && can_accept;
  assign grant_word = hold[grant_idx];
  assign push       = grant_vld && !is_dup && !new_work;

  // A new nonce is captured into an empty holder, or into one whose word is
  // leaving this very cycle; otherwise it is dropped.
  always_comb begin
    full_nxt = full;
    drop     = '0;
    capture  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_valid[i]) begin
        full_nxt[i] = 1'b1;
        if (!full[i] || (grant_vld && grant_idx == IW'(i)))
          capture[i] = 1'b1;
        else
          drop[i] = 1'b1;
      end else if (grant_vld && grant_idx == IW'(i)) begin
        full_nxt[i] = 1'b0;
      end
    end
  end

`ifdef GNA_DEDUP_EN
  logic [31:0] last_pushed;
  logic        last_vld;

  assign is_dup = last_vld && (grant_word == last_pushed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pushed <= 32'h0;
      last_vld    <= 1'b0;
    end else if (new_work) begin
      last_pushed <= 32'h0;
      last_vld    <= 1'b0;
    end else if (push) begin
      last_pushed <= grant_word;
      last_vld    <= 1'b1;
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  // Control state; flush overrides every other event in the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rr       <= '0;
      overflow <= 1'b0;
    end else if (new_work) begin
      full     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rr       <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (grant_vld) rr <= wrap_idx(grant_idx, 1);
      if (|drop) overflow <= 1'b1;
    end
  end

  // Data storage needs no reset: occupancy is tracked by full and the
  // pointers, and tx_data is forced to zero when the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (capture[i] && !new_work) hold[i] <= core_nonce[32*i +: 32];
    end
    if (push) mem[wr_ptr[PW-1:0]] <= grant_word;
  end

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// tb_golden_nonce_arbiter
//   Directed bench for golden_nonce_arbiter (NUM_CORES=4, FIFO_DEPTH=4).
//   Inputs change 1 ns after a rising edge; outputs are sampled there or on
//   the falling edge.
module tb_golden_nonce_arbiter;

  logic          clk;
  logic          rst_n;
  logic [3:0]    core_valid;
  logic [127:0]  core_nonce;
  logic          new_work;
  logic          tx_ready;
  logic          tx_valid;
  logic [31:0]   tx_data;
  logic          overflow;
  logic          pending;

  int            n_total;
  int            n_bad;
  int            cyc;
  logic [31:0]   obs [$];
  int            stamp [$];

  golden_nonce_arbiter #(.NUM_CORES(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_valid (core_valid),
    .core_nonce (core_nonce),
    .new_work   (new_work),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .overflow   (overflow),
    .pending    (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every word actually accepted by the framer at the next edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready && !new_work) begin
      obs.push_back(tx_data);
      stamp.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask, input logic [31:0] n0, input logic [31:0] n1,
                       input logic [31:0] n2, input logic [31:0] n3);
    core_valid = mask;
    core_nonce = {n3, n2, n1, n0};
    tick();
    core_valid = '0;
  endtask

  task automatic flush();
    new_work = 1'b1;
    tick();
    new_work = 1'b0;
    obs.delete();
    stamp.delete();
  endtask

  task automatic wait_words(input string tag, input int n, input int max_cyc);
    int c;
    c = 0;
    while (obs.size() < n && c < max_cyc) begin
      tick();
      c++;
    end
    chk(tag, 32'(obs.size()), 32'(n));
  endtask

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [31:0] exp_rr1 [4];
    logic [31:0] exp_rr2 [4];
    int          n_dedup;

    n_total    = 0;
    n_bad      = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    core_valid = '0;
    core_nonce = '0;
    new_work   = 1'b0;
    tx_ready   = 1'b0;

    repeat (3) tick();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data",  tx_data, 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_pending",  32'(pending), 0);
    rst_n = 1'b1;
    tick();

    // single core, no backpressure
    tx_ready = 1'b1;
    obs.delete();
    pulse(4'b0100, 0, 0, 32'h0000_1F3A, 0);
    chk("single_pend_e0",  32'(pending), 1);
    chk("single_valid_e0", 32'(tx_valid), 0);
    tick();
    chk("single_valid_e1", 32'(tx_valid), 1);
    chk("single_data_e1",  tx_data, 32'h0000_1F3A);
    tick();
    chk("single_valid_e2", 32'(tx_valid), 0);
    chk("single_pend_e2",  32'(pending), 0);
    chk("single_obs", obs_at(0), 32'h0000_1F3A);

    // round-robin from rr=0
    flush();
    exp_rr1 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    pulse(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    wait_words("rr0_cnt", 4, 20);
    for (int i = 0; i < 4; i++) chk($sformatf("rr0_w%0d", i), obs_at(i), exp_rr1[i]);
    for (int i = 1; i < 4 && i < stamp.size(); i++)
      chk($sformatf("rr0_gap%0d", i), 32'(stamp[i] - stamp[i-1]), 1);

    // grant to core 1 leaves rr=2
    obs.delete();
    stamp.delete();
    pulse(4'b0010, 0, 32'hB1, 0, 0);
    wait_words("rr_pre_cnt", 1, 10);
    chk("rr_pre_w", obs_at(0), 32'hB1);
    obs.delete();
    stamp.delete();
    exp_rr2 = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
    pulse(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    wait_words("rr2_cnt", 4, 20);
    for (int i = 0; i < 4; i++) chk($sformatf("rr2_w%0d", i), obs_at(i), exp_rr2[i]);

    // backpressure and overflow
    flush();
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pulse(4'b0001, 32'hC0 + 32'(k), 0, 0, 0);
      tick();
    end
    chk("bp_overflow", 32'(overflow), 1);
    chk("bp_pending",  32'(pending), 1);
    chk("bp_valid",    32'(tx_valid), 1);
    chk("bp_head",     tx_data, 32'hC0);
    tick();
    chk("bp_head_stable", tx_data, 32'hC0);
    tx_ready = 1'b1;
    wait_words("bp_cnt", 5, 20);
    repeat (4) tick();
    chk("bp_cnt_final", 32'(obs.size()), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_w%0d", i), obs_at(i), 32'hC0 + 32'(i));

    // flush priority
    flush();
    chk("flush_ovf_clr", 32'(overflow), 0);
    tx_ready = 1'b0;
    pulse(4'b0101, 32'hD0, 0, 32'hD2, 0);
    repeat (3) tick();
    chk("flush_pre_valid", 32'(tx_valid), 1);
    obs.delete();
    new_work   = 1'b1;
    tx_ready   = 1'b1;
    core_valid = 4'b0010;
    core_nonce = {32'h0, 32'h0, 32'hDD, 32'h0};
    tick();
    new_work   = 1'b0;
    core_valid = '0;
    chk("flush_valid",   32'(tx_valid), 0);
    chk("flush_pending", 32'(pending), 0);
    chk("flush_ovf",     32'(overflow), 0);
    repeat (5) tick();
    chk("flush_no_out",  32'(obs.size()), 0);

    // capture during grant
    flush();
    tx_ready = 1'b1;
    pulse(4'b1000, 0, 0, 0, 32'h10);
    pulse(4'b1000, 0, 0, 0, 32'h11);
    wait_words("cap_cnt", 2, 10);
    chk("cap_w0", obs_at(0), 32'h10);
    chk("cap_w1", obs_at(1), 32'h11);
    chk("cap_ovf", 32'(overflow), 0);

    // asynchronous reset mid-stream
    flush();
    tx_ready = 1'b0;
    pulse(4'b1111, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
    pulse(4'b1111, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
    tick();
    chk("ar_pre_ovf",   32'(overflow), 1);
    chk("ar_pre_valid", 32'(tx_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",   32'(tx_valid), 0);
    chk("ar_data",    tx_data, 0);
    chk("ar_ovf",     32'(overflow), 0);
    chk("ar_pending", 32'(pending), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_post_valid", 32'(tx_valid), 0);

    // dedup
    obs.delete();
    tx_ready = 1'b1;
    pulse(4'b0001, 32'h55, 0, 0, 0);
    repeat (3) tick();
    pulse(4'b0001, 32'h55, 0, 0, 0);
    repeat (8) tick();
`ifdef GNA_DEDUP_EN
    n_dedup = 1;
`else
    n_dedup = 2;
`endif
    chk("dedup_cnt", 32'(obs.size()), 32'(n_dedup));
    chk("dedup_w0",  obs_at(0), 32'h55);
    chk("dedup_ovf", 32'(overflow), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
